// File: rtl/escalonador_chamadas_pkg.sv
// Purpose : shared types, constants and target-selection helpers for the floor-call scheduler.
// Latency : combinational helpers only; no state.
// Backpr. : n/a. Optional PRIORIDADE_SENTIDO_EN selects escolhe_scan at the call site.
package pacote_elevador;

    localparam int N_ANDARES = 4;
    localparam int W_ANDAR   = 2;

    localparam logic SOBE  = 1'b1;
    localparam logic DESCE = 1'b0;

    typedef enum logic [1:0] {
        PARADO,
        SUBINDO,
        DESCENDO,
        PORTA
    } estado_t;

    // Nearest pending call strictly above and strictly below the current floor.
    typedef struct packed {
        logic               tem_acima;
        logic               tem_abaixo;
        logic [W_ANDAR-1:0] idx_acima;
        logic [W_ANDAR-1:0] idx_abaixo;
    } busca_t;

    // Chosen destination: valid flag, travel side, floor.
    typedef struct packed {
        logic               valido;
        logic               sentido;
        logic [W_ANDAR-1:0] andar;
    } alvo_t;

    // Priority search: the descending loop leaves the lowest call above,
    // the ascending loop leaves the highest call below.
    function automatic busca_t busca_chamadas(input logic [N_ANDARES-1:0] pend,
                                              input logic [W_ANDAR-1:0]   atual);
        busca_t b;
        b = '0;
        for (int i = N_ANDARES-1; i >= 0; i--) begin
            if ((i > int'(atual)) && pend[i]) begin
                b.tem_acima = 1'b1;
                b.idx_acima = i[W_ANDAR-1:0];
            end
        end
        for (int i = 0; i < N_ANDARES; i++) begin
            if ((i < int'(atual)) && pend[i]) begin
                b.tem_abaixo = 1'b1;
                b.idx_abaixo = i[W_ANDAR-1:0];
            end
        end
        return b;
    endfunction

    // Nearest pending floor by distance; equal distances go up.
    function automatic alvo_t escolhe_mais_proximo(input logic [N_ANDARES-1:0] pend,
                                                   input logic [W_ANDAR-1:0]   atual);
        busca_t             b;
        alvo_t              r;
        logic [W_ANDAR-1:0] dist_acima;
        logic [W_ANDAR-1:0] dist_abaixo;
        b           = busca_chamadas(pend, atual);
        r           = '0;
        dist_acima  = b.idx_acima - atual;
        dist_abaixo = atual - b.idx_abaixo;
        if (b.tem_acima && (!b.tem_abaixo || (dist_acima <= dist_abaixo))) begin
            r = '{valido: 1'b1, sentido: SOBE, andar: b.idx_acima};
        end else if (b.tem_abaixo) begin
            r = '{valido: 1'b1, sentido: DESCE, andar: b.idx_abaixo};
        end
        return r;
    endfunction

    // SCAN: keep the last direction while it still has calls, else reverse.
    function automatic alvo_t escolhe_scan(input logic [N_ANDARES-1:0] pend,
                                           input logic [W_ANDAR-1:0]   atual,
                                           input logic                 dir_ultima);
        busca_t b;
        alvo_t  r;
        logic   sobe;
        b    = busca_chamadas(pend, atual);
        r    = '0;
        sobe = (dir_ultima == SOBE) ? b.tem_acima : (b.tem_acima && !b.tem_abaixo);
        if (sobe) begin
            r = '{valido: 1'b1, sentido: SOBE, andar: b.idx_acima};
        end else if (b.tem_abaixo) begin
            r = '{valido: 1'b1, sentido: DESCE, andar: b.idx_abaixo};
        end
        return r;
    endfunction

endpackage

// File: rtl/escalonador_chamadas_if.sv
// Purpose : groups the scheduler's call inputs and counter/door outputs.
// Latency : wires only.
// Backpr. : none; master = floor/call environment, slave = scheduler.
interface escalonador_chamadas_if import pacote_elevador::*; ();

    logic                 tick_1hz;      // 1-cycle pulse, never back-to-back
    logic [N_ANDARES-1:0] chamada;       // debounced per-floor calls
    logic [W_ANDAR-1:0]   andar_atual;   // floor from the up/down counter
    logic                 lotado;        // occupancy alarm, holds door open
    logic                 direcao;       // 1 = up, 0 = down
    logic                 mover;         // counter step enable
    logic                 porta_aberta;  // door-open request
    logic [W_ANDAR-1:0]   andar_alvo;    // floor being travelled to
    logic [N_ANDARES-1:0] pendentes;     // latched outstanding calls

    modport master (
        output tick_1hz, chamada, andar_atual, lotado,
        input  direcao, mover, porta_aberta, andar_alvo, pendentes
    );

    modport slave (
        input  tick_1hz, chamada, andar_atual, lotado,
        output direcao, mover, porta_aberta, andar_alvo, pendentes
    );

endinterface

// File: rtl/escalonador_chamadas_temporizador.sv
// Purpose : door dwell counter in tick_1hz units; also reusable for obstruction timing.
// Latency : fim is combinational on the tick that completes TEMPO ticks.
// Backpr. : segura holds the count at 0; inicia restarts it and suppresses fim.
// Ports   : clock, reset (sync, active-low), tick_1hz, inicia, segura -> fim.
module temporizador_porta #(
    parameter int TEMPO = 3
) (
    input  logic clock,
    input  logic reset,
    input  logic tick_1hz,
    input  logic inicia,
    input  logic segura,
    output logic fim
);

    localparam int         W      = (TEMPO > 1) ? $clog2(TEMPO) : 1;
    localparam logic [W-1:0] ULTIMO = W'(TEMPO - 1);

    logic [W-1:0] cont_q, cont_d;

    assign fim = tick_1hz && !inicia && !segura && (cont_q == ULTIMO);

    always_comb begin
        cont_d = cont_q;
        if (inicia || segura) begin
            cont_d = '0;
        end else if (tick_1hz) begin
            cont_d = fim ? '0 : cont_q + W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            cont_q <= '0;
        end else begin
            cont_q <= cont_d;
        end
    end

endmodule

// File: rtl/escalonador_chamadas.sv
// Purpose : floor-call scheduler; latches calls, picks a target, drives direction/move/door.
// Latency : registered Moore outputs, one cycle from a latched call to the FSM decision.
// Backpr. : none; travel waits on andar_atual, door dwell waits on tick_1hz and lotado.
// Ports   : clock, reset (sync, active-low), bus (escalonador_chamadas_if.slave).
// Config  : PRIORIDADE_SENTIDO_EN selects SCAN target choice; default is nearest floor.
module escalonador_chamadas import pacote_elevador::*; #(
    parameter int TEMPO_PORTA = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    escalonador_chamadas_if.slave  bus
);

    estado_t              estado_q, estado_d;
    logic [N_ANDARES-1:0] pend_q, pend_d;
    logic                 dir_q, dir_d;
    logic                 mover_q, mover_d;
    logic                 porta_q, porta_d;
    logic [W_ANDAR-1:0]   alvo_q, alvo_d;

    logic [N_ANDARES-1:0] um_quente;
    logic [N_ANDARES-1:0] limpa;
    logic                 aqui_pend;
    logic                 absorve;
    logic                 inicia;
    logic                 fim;
    busca_t               busca;
    alvo_t                escolha;

    assign um_quente = {{(N_ANDARES-1){1'b0}}, 1'b1} << bus.andar_atual;

    // The served floor is cleared every cycle the door is open, so a
    // same-cycle set of that bit loses and a repeated press never re-latches.
    assign limpa     = (estado_q == PORTA) ? um_quente : '0;
    assign pend_d    = (pend_q | bus.chamada) & ~limpa;
    assign aqui_pend = pend_q[bus.andar_atual];

    // A press at the open floor keeps the door open for a fresh dwell.
    assign absorve = (estado_q == PORTA) && bus.chamada[bus.andar_atual];
    assign inicia  = (estado_q != PORTA) || absorve;

    assign busca = busca_chamadas(pend_q, bus.andar_atual);

    always_comb begin
`ifdef PRIORIDADE_SENTIDO_EN
        escolha = escolhe_scan(pend_q, bus.andar_atual, dir_q);
`else
        escolha = escolhe_mais_proximo(pend_q, bus.andar_atual);
`endif
    end

    temporizador_porta #(
        .TEMPO    (TEMPO_PORTA)
    ) u_temporizador (
        .clock    (clock),
        .reset    (reset),
        .tick_1hz (bus.tick_1hz),
        .inicia   (inicia),
        .segura   (bus.lotado),
        .fim      (fim)
    );

    always_comb begin
        estado_d = estado_q;
        dir_d    = dir_q;
        alvo_d   = alvo_q;
        unique case (estado_q)
            PARADO: begin
                if (aqui_pend) begin
                    estado_d = PORTA;
                    alvo_d   = bus.andar_atual;
                end else if (escolha.valido) begin
                    estado_d = (escolha.sentido == SOBE) ? SUBINDO : DESCENDO;
                    dir_d    = escolha.sentido;
                    alvo_d   = escolha.andar;
                end
            end
            SUBINDO: begin
                dir_d = SOBE;
                if (aqui_pend) begin
                    estado_d = PORTA;
                    alvo_d   = bus.andar_atual;
                end else if (!busca.tem_acima) begin
                    // Also covers the top floor, where nothing can be above.
                    estado_d = PARADO;
                end
            end
            DESCENDO: begin
                dir_d = DESCE;
                if (aqui_pend) begin
                    estado_d = PORTA;
                    alvo_d   = bus.andar_atual;
                end else if (!busca.tem_abaixo) begin
                    estado_d = PARADO;
                end
            end
            PORTA: begin
                if (fim) begin
                    estado_d = PARADO;
                end
            end
            default: begin
                estado_d = PARADO;
            end
        endcase
        mover_d = (estado_d == SUBINDO) || (estado_d == DESCENDO);
        porta_d = (estado_d == PORTA);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            estado_q <= PARADO;
            pend_q   <= '0;
            dir_q    <= SOBE;
            mover_q  <= 1'b0;
            porta_q  <= 1'b0;
            alvo_q   <= '0;
        end else begin
            estado_q <= estado_d;
            pend_q   <= pend_d;
            dir_q    <= dir_d;
            mover_q  <= mover_d;
            porta_q  <= porta_d;
            alvo_q   <= alvo_d;
        end
    end

    assign bus.direcao      = dir_q;
    assign bus.mover        = mover_q;
    assign bus.porta_aberta = porta_q;
    assign bus.andar_alvo   = alvo_q;
    assign bus.pendentes    = pend_q;

endmodule

// File: tb/tb_escalonador_chamadas.sv
module tb_escalonador_chamadas;

    logic clock;
    logic reset;

    escalonador_chamadas_if bus ();

    escalonador_chamadas #(.TEMPO_PORTA(3)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int   n_total  = 0;
    int   n_passou = 0;
    logic mover_visto;

    always @(negedge clock) begin
        if (bus.mover === 1'b1) mover_visto = 1'b1;
    end

    typedef struct {
        logic [1:0] andar;
        logic [3:0] ch;
        logic       e_mover;
        logic       e_dir;
        logic       e_porta;
        logic [1:0] e_alvo;
        logic [3:0] e_pend;
        string      nome;
    } vec_t;

    vec_t tab [10];

    task automatic chk(input string nome, input logic [31:0] real_v, input logic [31:0] esp);
        n_total++;
        if (real_v !== esp) begin
            $display("FAIL %s: got %0h, expected %0h", nome, real_v, esp);
        end else begin
            n_passou++;
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset        = 1'b0;
        bus.chamada  = '0;
        bus.tick_1hz = 1'b0;
        bus.lotado   = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    // Pulse a call for one cycle, then wait past the FSM decision edge.
    task automatic pulse(input logic [3:0] ch);
        bus.chamada = ch;
        @(negedge clock);
        bus.chamada = '0;
        @(negedge clock);
    endtask

    // One tick pulse (optionally with a call), counter steps like the real
    // up/down counter, then idle cycles so ticks are never consecutive.
    task automatic tick(input logic [3:0] ch);
        logic m, d;
        bus.tick_1hz = 1'b1;
        bus.chamada  = ch;
        m = bus.mover;
        d = bus.direcao;
        @(negedge clock);
        bus.tick_1hz = 1'b0;
        bus.chamada  = '0;
        if (m) bus.andar_atual = d ? bus.andar_atual + 2'd1 : bus.andar_atual - 2'd1;
        repeat (3) @(negedge clock);
    endtask

    initial begin
        reset           = 1'b0;
        bus.tick_1hz    = 1'b0;
        bus.chamada     = '0;
        bus.andar_atual = '0;
        bus.lotado      = 1'b0;
        mover_visto     = 1'b0;

        //            floor  calls    mov   dir   porta alvo  pend
        tab[0] = '{2'd0, 4'b1000, 1'b1, 1'b1, 1'b0, 2'd3, 4'b1000, "f0_up3"};
        tab[1] = '{2'd1, 4'b0101, 1'b1, 1'b1, 1'b0, 2'd2, 4'b0101, "f1_tie"};
`ifdef PRIORIDADE_SENTIDO_EN
        tab[2] = '{2'd1, 4'b1001, 1'b1, 1'b1, 1'b0, 2'd3, 4'b1001, "f1_near"};
`else
        tab[2] = '{2'd1, 4'b1001, 1'b1, 1'b0, 1'b0, 2'd0, 4'b1001, "f1_near"};
`endif
        tab[3] = '{2'd3, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0000, "f3_idle"};
        tab[4] = '{2'd0, 4'b0001, 1'b0, 1'b1, 1'b1, 2'd0, 4'b0001, "f0_here"};
        tab[5] = '{2'd2, 4'b0010, 1'b1, 1'b0, 1'b0, 2'd1, 4'b0010, "f2_dn1"};
        tab[6] = '{2'd3, 4'b0001, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0001, "f3_dn0"};
        tab[7] = '{2'd0, 4'b0110, 1'b1, 1'b1, 1'b0, 2'd1, 4'b0110, "f0_up1"};
        tab[8] = '{2'd2, 4'b1010, 1'b1, 1'b1, 1'b0, 2'd3, 4'b1010, "f2_tie"};
        tab[9] = '{2'd3, 4'b1000, 1'b0, 1'b1, 1'b1, 2'd3, 4'b1000, "f3_here"};

        for (int k = 0; k < 10; k++) begin
            bus.andar_atual = tab[k].andar;
            do_reset();
            chk({tab[k].nome, "/rst_mover"}, 32'(bus.mover),        32'd0);
            chk({tab[k].nome, "/rst_dir"},   32'(bus.direcao),      32'd1);
            chk({tab[k].nome, "/rst_pend"},  32'(bus.pendentes),    32'd0);
            pulse(tab[k].ch);
            chk({tab[k].nome, "/mover"},     32'(bus.mover),        32'(tab[k].e_mover));
            chk({tab[k].nome, "/dir"},       32'(bus.direcao),      32'(tab[k].e_dir));
            chk({tab[k].nome, "/porta"},     32'(bus.porta_aberta), 32'(tab[k].e_porta));
            chk({tab[k].nome, "/alvo"},      32'(bus.andar_alvo),   32'(tab[k].e_alvo));
            chk({tab[k].nome, "/pend"},      32'(bus.pendentes),    32'(tab[k].e_pend));
        end

        // Reset for two cycles in the middle of upward travel.
        bus.andar_atual = 2'd0;
        do_reset();
        pulse(4'b1010);
        chk("midrst/moving", 32'(bus.mover), 32'd1);
        do_reset();
        chk("midrst/mover", 32'(bus.mover),        32'd0);
        chk("midrst/porta", 32'(bus.porta_aberta), 32'd0);
        chk("midrst/pend",  32'(bus.pendentes),    32'd0);
        chk("midrst/dir",   32'(bus.direcao),      32'd1);
        chk("midrst/alvo",  32'(bus.andar_alvo),   32'd0);

        // Full trip 0 -> 3 with the counter stepping on ticks, then dwell.
        bus.andar_atual = 2'd0;
        do_reset();
        pulse(4'b1000);
        tick(4'b0000);
        chk("trip/floor1_moving", 32'(bus.mover), 32'd1);
        tick(4'b0000);
        tick(4'b0000);
        chk("trip/floor",  32'(bus.andar_atual),  32'd3);
        chk("trip/porta",  32'(bus.porta_aberta), 32'd1);
        chk("trip/mover",  32'(bus.mover),        32'd0);
        chk("trip/pend",   32'(bus.pendentes),    32'd0);
        chk("trip/alvo",   32'(bus.andar_alvo),   32'd3);
        tick(4'b0000);
        chk("trip/dwell1", 32'(bus.porta_aberta), 32'd1);
        tick(4'b0000);
        chk("trip/dwell2", 32'(bus.porta_aberta), 32'd1);
        tick(4'b0000);
        chk("trip/closed", 32'(bus.porta_aberta), 32'd0);
        chk("trip/idle",   32'(bus.mover),        32'd0);

        // Occupancy alarm holds the door; dwell restarts on release.
        bus.andar_atual = 2'd2;
        do_reset();
        pulse(4'b0100);
        chk("lotado/open", 32'(bus.porta_aberta), 32'd1);
        bus.lotado = 1'b1;
        repeat (10) tick(4'b0000);
        chk("lotado/held", 32'(bus.porta_aberta), 32'd1);
        bus.lotado = 1'b0;
        tick(4'b0000);
        tick(4'b0000);
        chk("lotado/rel2", 32'(bus.porta_aberta), 32'd1);
        tick(4'b0000);
        chk("lotado/closed", 32'(bus.porta_aberta), 32'd0);

        // Re-press on the expiring tick: dwell restarts, call not latched.
        bus.andar_atual = 2'd2;
        do_reset();
        pulse(4'b0100);
        tick(4'b0000);
        tick(4'b0000);
        tick(4'b0100);
        chk("repress/open", 32'(bus.porta_aberta), 32'd1);
        chk("repress/pend", 32'(bus.pendentes),    32'd0);
        tick(4'b0000);
        tick(4'b0000);
        chk("repress/dwell2", 32'(bus.porta_aberta), 32'd1);
        tick(4'b0000);
        chk("repress/closed", 32'(bus.porta_aberta), 32'd0);

        // Call at the current ground floor: door only, mover never rises.
        bus.andar_atual = 2'd0;
        do_reset();
        mover_visto = 1'b0;
        pulse(4'b0001);
        chk("f0/porta", 32'(bus.porta_aberta), 32'd1);
        repeat (3) tick(4'b0000);
        chk("f0/closed",      32'(bus.porta_aberta), 32'd0);
        chk("f0/pend",        32'(bus.pendentes),    32'd0);
        chk("f0/mover_never", 32'(mover_visto),      32'd0);

        $display("%0d/%0d checks passed", n_passou, n_total);
        $finish;
    end

endmodule
